// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a DEPTH-entry FIFO over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       tx_en_i,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [FW-1:0] r_fill;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic       w_push;
  logic       w_can_pop;
  logic       w_bit_end;
  logic       w_pop;
  logic [7:0] w_head;

  assign ready_o   = (r_fill != FILL_MAX);
  assign fill_o    = r_fill;
  assign w_push    = valid_i && ready_o;
  assign w_can_pop = (r_fill != '0) && tx_en_i;
  assign w_bit_end = (r_cnt == CNT_MAX);
  // A pop starts a frame: from IDLE, or chained onto the last stop-bit cycle.
  assign w_pop     = w_can_pop && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_cnt <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_cnt + 1'b1;
      if (w_pop) begin
        r_state <= S_START;
        r_cnt   <= '0;
        r_shift <= w_head;
        tx_o    <= 1'b0;
        busy_o  <= 1'b1;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^w_head;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
          S_START: if (w_bit_end) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            tx_o    <= r_shift[0];
          end
          S_DATA: if (w_bit_end) begin
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              tx_o    <= r_par;
`else
              r_state <= S_STOP;
              tx_o    <= 1'b1;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              tx_o    <= r_shift[1];
              r_bit   <= r_bit + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: if (w_bit_end) begin
            r_state <= S_STOP;
            tx_o    <= 1'b1;
          end
`endif
          S_STOP: if (w_bit_end) begin
            r_state <= S_IDLE;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
